// File: rtl/sawtooth_analyzer.sv
// -----------------------------------------------------------------------------
// sawtooth_analyzer
//
// Purpose:
//    Measures the period and the peak/trough span of an 8-bit sawtooth sample
//    stream, one sample per enabled clock. A ramp wrap is a fall between
//    consecutive accepted samples that is strictly larger than DROP_THRESHOLD.
//    Each complete ramp is reported with a one-cycle measValid pulse. If no
//    wrap arrives within MAX_PERIOD samples, a sticky noSignal flag is raised.
//
// Parameters:
//    PERIOD_WIDTH   - width of the period counter and of periodOut
//    MAX_PERIOD     - largest reportable period (<= 2**PERIOD_WIDTH-1)
//    DROP_THRESHOLD - exclusive minimum fall that counts as a wrap (< 256)
//
// Ports:
//    clk        in   single clock, rising edge
//    reset      in   synchronous, active-high
//    enable     in   sampleIn is accepted on this edge when high
//    sampleIn   in   8-bit unsigned waveform sample
//    periodOut  out  last measured period, in accepted samples
//    peakOut    out  maximum sample of the last measured period
//    troughOut  out  minimum sample of the last measured period
//    measValid  out  one-cycle pulse when the outputs were updated
//    noSignal   out  sticky: no valid measurement since reset or timeout
// -----------------------------------------------------------------------------
module sawtooth_analyzer #(
   parameter int unsigned PERIOD_WIDTH   = 24,
   parameter int unsigned MAX_PERIOD     = (2 ** 24) - 1,
   parameter int unsigned DROP_THRESHOLD = 64
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    enable,
   input  logic [7:0]              sampleIn,
   output logic [PERIOD_WIDTH-1:0] periodOut,
   output logic [7:0]              peakOut,
   output logic [7:0]              troughOut,
   output logic                    measValid,
   output logic                    noSignal
);

   typedef enum logic [1:0] {
      IDLE,
      SYNC,
      MEASURE
   } state_t;

   state_t                  state_q, state_d;
   logic [PERIOD_WIDTH-1:0] count_q, count_d;
   logic [7:0]              prevSample_q, prevSample_d;
   logic [7:0]              peak_q, peak_d;
   logic [7:0]              trough_q, trough_d;

   // One-cycle staging between the wrap/timeout decision and the outputs
   logic                    pendValid_q, pendValid_d;
   logic                    pendTimeout_q, pendTimeout_d;
   logic [PERIOD_WIDTH-1:0] pendPeriod_q, pendPeriod_d;
   logic [7:0]              pendPeak_q, pendPeak_d;
   logic [7:0]              pendTrough_q, pendTrough_d;

   logic [PERIOD_WIDTH-1:0] periodOut_q;
   logic [7:0]              peakOut_q;
   logic [7:0]              troughOut_q;
   logic                    measValid_q;
   logic                    noSignal_q;

   logic [7:0]              dropAmount;
   logic                    isWrap;
   logic                    isTimeout;

   // The fall is only meaningful when the new sample is below the previous
   // one, so the subtraction is gated to avoid comparing an 8-bit underflow.
   always_comb begin
      dropAmount = 8'd0;
      if (prevSample_q > sampleIn) begin
         dropAmount = prevSample_q - sampleIn;
      end
      isWrap    = (prevSample_q > sampleIn) && (dropAmount > 8'(DROP_THRESHOLD));
      isTimeout = (count_q == PERIOD_WIDTH'(MAX_PERIOD));
   end

   // Next-state logic. Nothing advances unless a sample is accepted. A wrap
   // in MEASURE snapshots the running count/peak/trough into the staging
   // registers before restarting them from the wrap sample, which belongs to
   // the next period. A timeout is only possible on a non-wrap sample and
   // always drops back to SYNC so a fresh ramp is needed before reporting.
   always_comb begin
      state_d       = state_q;
      count_d       = count_q;
      prevSample_d  = prevSample_q;
      peak_d        = peak_q;
      trough_d      = trough_q;
      pendValid_d   = 1'b0;
      pendTimeout_d = 1'b0;
      pendPeriod_d  = pendPeriod_q;
      pendPeak_d    = pendPeak_q;
      pendTrough_d  = pendTrough_q;

      if (enable) begin
         prevSample_d = sampleIn;
         case (state_q)
            IDLE: begin
               state_d = SYNC;
               count_d = PERIOD_WIDTH'(1);
            end
            SYNC: begin
               if (isWrap) begin
                  state_d  = MEASURE;
                  count_d  = PERIOD_WIDTH'(1);
                  peak_d   = sampleIn;
                  trough_d = sampleIn;
               end else if (isTimeout) begin
                  pendTimeout_d = 1'b1;
                  count_d       = PERIOD_WIDTH'(1);
               end else begin
                  count_d = count_q + PERIOD_WIDTH'(1);
               end
            end
            MEASURE: begin
               if (isWrap) begin
                  pendValid_d  = 1'b1;
                  pendPeriod_d = count_q;
                  pendPeak_d   = peak_q;
                  pendTrough_d = trough_q;
                  count_d      = PERIOD_WIDTH'(1);
                  peak_d       = sampleIn;
                  trough_d     = sampleIn;
               end else if (isTimeout) begin
                  pendTimeout_d = 1'b1;
                  state_d       = SYNC;
                  count_d       = PERIOD_WIDTH'(1);
               end else begin
                  count_d = count_q + PERIOD_WIDTH'(1);
                  if (sampleIn > peak_q) begin
                     peak_d = sampleIn;
                  end
                  if (sampleIn < trough_q) begin
                     trough_d = sampleIn;
                  end
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   // State and staging registers. Reset clears the staging flags, which is
   // what drops a measurement that was decided but not yet published.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         count_q       <= '0;
         prevSample_q  <= 8'd0;
         peak_q        <= 8'd0;
         trough_q      <= 8'd0;
         pendValid_q   <= 1'b0;
         pendTimeout_q <= 1'b0;
         pendPeriod_q  <= '0;
         pendPeak_q    <= 8'd0;
         pendTrough_q  <= 8'd0;
      end else begin
         state_q       <= state_d;
         count_q       <= count_d;
         prevSample_q  <= prevSample_d;
         peak_q        <= peak_d;
         trough_q      <= trough_d;
         pendValid_q   <= pendValid_d;
         pendTimeout_q <= pendTimeout_d;
         pendPeriod_q  <= pendPeriod_d;
         pendPeak_q    <= pendPeak_d;
         pendTrough_q  <= pendTrough_d;
      end
   end

   // Output stage: publishes the staged result one edge after the decision.
   // This stage runs every cycle, independent of enable, so the pulse is
   // never stretched by a gap in the sample stream.
   always_ff @(posedge clk) begin
      if (reset) begin
         periodOut_q <= '0;
         peakOut_q   <= 8'd0;
         troughOut_q <= 8'd0;
         measValid_q <= 1'b0;
         noSignal_q  <= 1'b1;
      end else begin
         measValid_q <= pendValid_q;
         if (pendValid_q) begin
            periodOut_q <= pendPeriod_q;
            peakOut_q   <= pendPeak_q;
            troughOut_q <= pendTrough_q;
            noSignal_q  <= 1'b0;
         end else if (pendTimeout_q) begin
            noSignal_q  <= 1'b1;
         end
      end
   end

   assign periodOut = periodOut_q;
   assign peakOut   = peakOut_q;
   assign troughOut = troughOut_q;
   assign measValid = measValid_q;
   assign noSignal  = noSignal_q;

endmodule

// File: tb/tb_sawtooth_analyzer.sv
// -----------------------------------------------------------------------------
// tb_sawtooth_analyzer
//
// Directed testbench for sawtooth_analyzer with MAX_PERIOD reduced to 16 so
// the timeout is reachable. Inputs are driven 1 time unit after each rising
// edge and outputs are sampled at the same point, so each applyStimulus call
// covers exactly one accepted (or skipped) edge.
// -----------------------------------------------------------------------------
module tb_sawtooth_analyzer;

   localparam int PW = 24;

   logic          clk;
   logic          reset;
   logic          enable;
   logic [7:0]    sampleIn;
   logic [PW-1:0] periodOut;
   logic [7:0]    peakOut;
   logic [7:0]    troughOut;
   logic          measValid;
   logic          noSignal;

   int testCount = 0;
   int failCount = 0;

   // Threshold sequence: 120->56 is a 64 fall (not a wrap, from SYNC),
   // 200->135 is a 65 fall (wrap into MEASURE), 170->106 is a 64 fall inside
   // MEASURE (not a wrap), 140->40 is a wrap that reports 135,150,170,106,140.
   logic [7:0] thrSeq [11] = '{8'd100, 8'd120, 8'd56, 8'd200, 8'd135, 8'd150,
                               8'd170, 8'd106, 8'd140, 8'd40, 8'd40};

   sawtooth_analyzer #(
      .PERIOD_WIDTH(PW),
      .MAX_PERIOD(16),
      .DROP_THRESHOLD(64)
   ) dut (
      .clk(clk),
      .reset(reset),
      .enable(enable),
      .sampleIn(sampleIn),
      .periodOut(periodOut),
      .peakOut(peakOut),
      .troughOut(troughOut),
      .measValid(measValid),
      .noSignal(noSignal)
   );

   // Free-running clock, period 10
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      testCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end
   endtask

   // Drive one cycle of inputs and advance past the next rising edge
   task automatic applyStimulus(input logic en, input logic [7:0] s);
      enable   = en;
      sampleIn = s;
      @(posedge clk);
      #1;
   endtask

   // Hold reset for n cycles with arbitrary inputs on the data pins
   task automatic applyReset(input int n);
      reset = 1'b1;
      for (int i = 0; i < n; i++) begin
         applyStimulus(1'($urandom), 8'($urandom));
      end
      reset = 1'b0;
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, ".periodOut"}, 32'(periodOut), 32'd0);
      checkOutput({tag, ".peakOut"},   32'(peakOut),   32'd0);
      checkOutput({tag, ".troughOut"}, 32'(troughOut), 32'd0);
      checkOutput({tag, ".measValid"}, 32'(measValid), 32'd0);
      checkOutput({tag, ".noSignal"},  32'(noSignal),  32'd1);
   endtask

   // Ramps 0,32,...,224 starting from IDLE. The wrap at ramp 2 only syncs;
   // the wraps at ramps 3 and 4 (accepted samples 16 and 24) each publish a
   // period of 8, visible one edge later. With gaps, every accepted sample
   // is followed by a disabled cycle carrying random data.
   task automatic runRamps(input string tag, input int nSamples, input bit gapped);
      int   stride;
      logic en;
      logic [7:0] s;
      logic expV;
      stride = gapped ? 2 : 1;
      for (int c = 0; c < nSamples * stride; c++) begin
         en = ((c % stride) == 0);
         s  = en ? 8'(32 * ((c / stride) % 8)) : 8'($urandom);
         applyStimulus(en, s);
         expV = (c == 16 * stride + 1) || (c == 24 * stride + 1);
         checkOutput({tag, ".measValid"}, 32'(measValid), 32'(expV));
         if (expV) begin
            checkOutput({tag, ".periodOut"}, 32'(periodOut), 32'd8);
            checkOutput({tag, ".peakOut"},   32'(peakOut),   32'd224);
            checkOutput({tag, ".troughOut"}, 32'(troughOut), 32'd0);
            checkOutput({tag, ".noSignal"},  32'(noSignal),  32'd0);
         end
      end
   endtask

   initial begin
      reset    = 1'b1;
      enable   = 1'b0;
      sampleIn = 8'd0;

      // Reset state
      applyReset(3);
      checkResetValues("reset");

      // Continuous ramp, four periods
      runRamps("ramp", 32, 1'b0);

      // Timeout: 224->50 is a wrap reporting ramp 4, then 50 is held.
      // Sample k=16 is the 16th accepted after that wrap and times out.
      for (int k = 0; k < 18; k++) begin
         applyStimulus(1'b1, 8'd50);
         checkOutput("timeout.measValid", 32'(measValid), 32'(k == 1));
         checkOutput("timeout.noSignal", 32'(noSignal), 32'(k >= 17));
         if (k == 1 || k == 17) begin
            checkOutput("timeout.periodOut", 32'(periodOut), 32'd8);
         end
      end
      // Resync needs a full ramp before reporting again
      runRamps("resync", 24, 1'b0);

      // Gapped ramp
      applyReset(1);
      checkResetValues("gapReset");
      runRamps("gapped", 32, 1'b1);

      // Threshold boundary
      applyReset(1);
      for (int i = 0; i < 11; i++) begin
         applyStimulus(1'b1, thrSeq[i]);
         checkOutput("thresh.measValid", 32'(measValid), 32'(i == 10));
      end
      checkOutput("thresh.periodOut", 32'(periodOut), 32'd5);
      checkOutput("thresh.peakOut",   32'(peakOut),   32'd170);
      checkOutput("thresh.troughOut", 32'(troughOut), 32'd106);
      checkOutput("thresh.noSignal",  32'(noSignal),  32'd0);

      // Reset in the cycle after a wrap whose pulse is still pending
      applyReset(1);
      runRamps("preMid", 32, 1'b0);
      applyStimulus(1'b1, 8'd0);
      checkOutput("midWrap.measValid", 32'(measValid), 32'd0);
      applyReset(1);
      checkResetValues("midReset");
      runRamps("afterMid", 32, 1'b0);

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
